// File: rtl/mul_sfx_ufx_pkg.sv
// Shared constants for the signed x unsigned fixed-point multiplier:
// mode bit positions and the exact product width.
package mul_sfx_ufx_pkg;

   localparam int MODE_RND = 0;
   localparam int MODE_SAT = 1;

   // The unsigned operand gains a zero sign bit, so the product is exact in SW+UW+1 bits.
   function automatic int prod_width(input int sw, input int uw);
      return sw + uw + 1;
   endfunction

endpackage

// File: rtl/sfx_round_sat.sv
// Combinational post-processing of an exact signed product: optional half-up
// rounding, arithmetic right shift by FRAC, then saturate or wrap to OW bits.
module sfx_round_sat
   import mul_sfx_ufx_pkg::*;
#(
   parameter int PW   = 41,
   parameter int OW   = 32,
   parameter int FRAC = 0
)
(
   input  logic signed [PW-1:0] prod,
   input  logic [1:0]           mode,
   output logic signed [OW-1:0] result,
   output logic                 ovf
);

   // One guard bit for the rounding carry, and always at least one bit wider than OW.
   localparam int WW = ((PW + 1 > OW) ? PW + 1 : OW) + 1;
   localparam int RS = (FRAC > 0) ? FRAC - 1 : 0;

   logic signed [WW-1:0] prod_x;
   logic signed [WW-1:0] rnd_add;
   logic signed [WW-1:0] sum;
   logic signed [WW-1:0] shifted;
   logic signed [WW-1:0] back;
   logic signed [OW-1:0] low;

   assign prod_x = WW'(prod);

   always_comb begin
      rnd_add = '0;
      if (mode[MODE_RND] && (FRAC > 0)) begin
         rnd_add = WW'(1) << RS;
      end
   end

   assign sum     = prod_x + rnd_add;
   assign shifted = sum >>> FRAC;
   assign low     = shifted[OW-1:0];
   assign back    = WW'(low);
   assign ovf     = (back != shifted);

   always_comb begin
      result = low;
      if (ovf && mode[MODE_SAT]) begin
         result = shifted[WW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mul_sfx_ufx_pipe.sv
// Pipelined signed x unsigned fixed-point multiplier with valid/ready flow control.
// Stages 1..STAGES-1 carry the product; the final stage rounds/saturates into the output register.
module mul_sfx_ufx_pipe
   import mul_sfx_ufx_pkg::*;
#(
   parameter int SW     = 32,
   parameter int UW     = 8,
   parameter int OW     = 32,
   parameter int FRAC   = 0,
   parameter int STAGES = 3
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SW-1:0]        sd,
   input  logic [UW-1:0]        ud,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [OW-1:0] result,
   output logic                 ovf
);

   localparam int PW = prod_width(SW, UW);

   logic                 adv;
   logic signed [SW-1:0] sd_s;
   logic signed [UW:0]   ud_s;
   logic signed [PW-1:0] prod_c;

   logic [STAGES-1:1]    vld_reg;
   logic [STAGES-1:1]    vld_next;
   logic signed [PW-1:0] prod_reg  [1:STAGES-1];
   logic signed [PW-1:0] prod_next [1:STAGES-1];
   logic [1:0]           mode_reg  [1:STAGES-1];
   logic [1:0]           mode_next [1:STAGES-1];

   logic                 out_valid_reg;
   logic signed [OW-1:0] result_reg;
   logic                 ovf_reg;
   logic signed [OW-1:0] rs_result;
   logic                 rs_ovf;

   // Whole pipeline moves in lockstep; it only freezes when the output holds an unaccepted beat.
   assign adv      = !out_valid_reg || out_ready;
   assign in_ready = adv;

   assign sd_s   = sd;
   assign ud_s   = {1'b0, ud};
   assign prod_c = PW'(sd_s) * PW'(ud_s);

   genvar gi;
   generate
      for (gi = 1; gi < STAGES; gi++) begin : g_stage
         if (gi == 1) begin : g_first
            assign vld_next[gi]  = in_valid;
            assign prod_next[gi] = prod_c;
            assign mode_next[gi] = mode;
         end else begin : g_rest
            assign vld_next[gi]  = vld_reg[gi-1];
            assign prod_next[gi] = prod_reg[gi-1];
            assign mode_next[gi] = mode_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_reg <= '0;
      end else if (adv) begin
         vld_reg <= vld_next;
      end
   end

   // Payload registers carry no reset; their contents are qualified by vld_reg.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int i = 1; i < STAGES; i++) begin
            prod_reg[i] <= prod_next[i];
            mode_reg[i] <= mode_next[i];
         end
      end
   end

   sfx_round_sat #(
      .PW   (PW),
      .OW   (OW),
      .FRAC (FRAC)
   ) u_round_sat (
      .prod   (prod_reg[STAGES-1]),
      .mode   (mode_reg[STAGES-1]),
      .result (rs_result),
      .ovf    (rs_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         result_reg    <= '0;
         ovf_reg       <= 1'b0;
      end else if (adv) begin
         out_valid_reg <= vld_reg[STAGES-1];
         if (vld_reg[STAGES-1]) begin
            result_reg <= rs_result;
            ovf_reg    <= rs_ovf;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign result    = result_reg;
   assign ovf       = ovf_reg;

endmodule

// File: tb/tb_mul_sfx_ufx_pipe.sv
// Self-checking bench: three parameterisations run in lockstep on a shared stimulus bus
// (defaults, FRAC=8, OW=16), checked against vector tables and a plain-arithmetic model.
module tb_mul_sfx_ufx_pipe;

   localparam int ST = 3;
   localparam int NB = 1000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b1;
   logic [31:0] sd = '0;
   logic [7:0]  ud = '0;
   logic [1:0]  mode = '0;

   logic in_ready0, in_ready1, in_ready2;
   logic out_valid0, out_valid1, out_valid2;
   logic signed [31:0] res0, res1;
   logic signed [15:0] res2;
   logic ovf0, ovf1, ovf2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_sfx_ufx_pipe dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .sd(sd), .ud(ud), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
      .result(res0), .ovf(ovf0));

   mul_sfx_ufx_pipe #(.FRAC(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .sd(sd), .ud(ud), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
      .result(res1), .ovf(ovf1));

   mul_sfx_ufx_pipe #(.OW(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .sd(sd), .ud(ud), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready),
      .result(res2), .ovf(ovf2));

   typedef struct {
      int          inst;
      logic [31:0] sd;
      logic [7:0]  ud;
      logic [1:0]  mode;
      int          res;
      int          ovf;
   } vec_t;

   typedef struct {
      longint r0, r1, r2;
      logic   o0, o1, o2;
   } exp_t;

   vec_t tbl [16];
   int   ntbl = 0;
   exp_t q [$];

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic add_vec(input int inst, input int s, input int u, input int m, input int r, input int o);
      tbl[ntbl].inst = inst;
      tbl[ntbl].sd   = s;
      tbl[ntbl].ud   = u[7:0];
      tbl[ntbl].mode = m[1:0];
      tbl[ntbl].res  = r;
      tbl[ntbl].ovf  = o;
      ntbl++;
   endtask

   // Reference: exact product, optional +half, floor shift, then clamp or modular wrap.
   function automatic void model(input logic signed [31:0] a, input logic [7:0] b, input logic [1:0] m,
                                 input int frac, input int ow, output longint r, output logic o);
      longint p, mx, mn, span;
      p = longint'(a) * longint'({1'b0, b});
      if (m[0] && frac > 0) p = p + (longint'(1) << (frac - 1));
      p = p >>> frac;
      mx = (longint'(1) << (ow - 1)) - 1;
      mn = -mx - 1;
      span = longint'(1) << ow;
      o = (p > mx) || (p < mn);
      if (!o) r = p;
      else if (m[1]) r = (p < 0) ? mn : mx;
      else begin
         r = p % span;
         if (r > mx) r = r - span;
         if (r < mn) r = r + span;
      end
   endfunction

   function automatic logic signed [63:0] get_res(input int inst);
      if (inst == 0) return res0;
      if (inst == 1) return res1;
      return res2;
   endfunction

   function automatic logic get_ovf(input int inst);
      if (inst == 0) return ovf0;
      if (inst == 1) return ovf1;
      return ovf2;
   endfunction

   function automatic logic get_vld(input int inst);
      if (inst == 0) return out_valid0;
      if (inst == 1) return out_valid1;
      return out_valid2;
   endfunction

   task automatic run_vec(input int i);
      @(negedge clk);
      sd = tbl[i].sd; ud = tbl[i].ud; mode = tbl[i].mode;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (ST - 2) @(negedge clk);
      #1;
      check($sformatf("vec%0d_early_valid", i), get_vld(tbl[i].inst), 0);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_valid", i), get_vld(tbl[i].inst), 1);
      check($sformatf("vec%0d_result", i), get_res(tbl[i].inst), tbl[i].res);
      check($sformatf("vec%0d_ovf", i), get_ovf(tbl[i].inst), tbl[i].ovf);
      $display("vec %0d inst=%0d sd=%0d ud=%0d mode=%b -> result=%0d ovf=%0d",
               i, tbl[i].inst, $signed(tbl[i].sd), tbl[i].ud, tbl[i].mode, get_res(tbl[i].inst), get_ovf(tbl[i].inst));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int sent, got, cyc, nv;
      logic stall;
      logic signed [63:0] held_a, held_b;
      exp_t e;
      int exp1 [4];
      int exp2 [4];

      add_vec(0, -200, 200, 0, -40000, 0);
      add_vec(1, -200, 200, 0, -157, 0);
      add_vec(1, -200, 200, 1, -156, 0);
      add_vec(2, 32767, 255, 2, 32767, 1);
      add_vec(2, 32767, 255, 0, 32513, 1);
      add_vec(2, -32768, 255, 2, -32768, 1);
      add_vec(0, -2147483647 - 1, 255, 3, -2147483647 - 1, 1);
      add_vec(0, 2147483647, 255, 0, 2147483393, 1);
      add_vec(1, 1, 128, 1, 1, 0);
      add_vec(1, 1, 128, 0, 0, 0);
      add_vec(1, -1, 128, 1, 0, 0);
      add_vec(1, -1, 128, 0, -1, 0);
      add_vec(0, 5, 0, 3, 0, 0);
      add_vec(2, -32768, 1, 2, -32768, 0);
      add_vec(2, 32768, 1, 0, -32768, 1);
      add_vec(2, 32767, 1, 3, 32767, 0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", {out_valid0, out_valid1, out_valid2}, 0);
      check("rst_result", {res0, res1}, 0);
      check("rst_result16", res2, 0);
      check("rst_ovf", {ovf0, ovf1, ovf2}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", {in_ready0, in_ready1, in_ready2}, 3'b111);

      for (int i = 0; i < ntbl; i++) run_vec(i);

      // Alternating modes at full rate
      exp1 = '{-157, -156, -157, -156};
      exp2 = '{25536, 25536, -32768, -32768};
      got = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < 4) begin
            sd = -200; ud = 8'd200; mode = 2'(k); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid0 && got < 4) begin
            check($sformatf("alt%0d_r0", got), res0, -40000);
            check($sformatf("alt%0d_r1", got), res1, exp1[got]);
            check($sformatf("alt%0d_r2", got), res2, exp2[got]);
            check($sformatf("alt%0d_ovf", got), {ovf0, ovf1, ovf2}, 3'b001);
            $display("alt beat %0d mode=%0d r1=%0d r2=%0d", got, got, res1, res2);
            got++;
         end else if (out_valid0) begin
            check("alt_extra_output", got, 4);
         end
      end
      check("alt_count", got, 4);

      // Reset with three beats in flight
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k < 3) begin
            sd = 1000 + k; ud = 8'd3; mode = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
         end else begin
            in_valid = 1'b0;
            rst_n = 1'b0;
         end
      end
      #1;
      check("midrst_valid", {out_valid0, out_valid1, out_valid2}, 0);
      check("midrst_result", res0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      for (int k = 0; k < ST + 4; k++) begin
         @(negedge clk);
         #1;
         if (out_valid0 || out_valid1 || out_valid2) nv++;
      end
      check("midrst_no_output", nv, 0);
      $display("mid-reset flush: outputs after release=%0d", nv);
      run_vec(0);

      // Randomized flow control against the model
      sent = 0; got = 0; cyc = 0; stall = 1'b0;
      held_a = '0; held_b = '0;
      while (got < NB && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (stall) begin
            check("stall_hold_r01", {res0, res1}, held_a);
            check("stall_hold_misc", {res2, ovf0, ovf1, ovf2, out_valid0}, held_b);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid = (sent < NB) && ($urandom_range(0, 3) != 0);
         sd = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 600)) - 32'd300);
         ud = 8'($urandom);
         mode = 2'($urandom);
         #1;
         check("in_ready", in_ready0, !out_valid0 || out_ready);
         if (out_valid0 && out_ready) begin
            if (q.size() == 0) begin
               check("rand_unexpected_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("rand_r0", res0, e.r0);
               check("rand_r1", res1, e.r1);
               check("rand_r2", res2, e.r2);
               check("rand_ovf", {ovf0, ovf1, ovf2}, {e.o0, e.o1, e.o2});
               $display("rand beat %0d r0=%0d r1=%0d r2=%0d ovf=%b%b%b", got, res0, res1, res2, ovf0, ovf1, ovf2);
               got++;
            end
         end
         if (in_valid && in_ready0) begin
            model(sd, ud, mode, 0, 32, e.r0, e.o0);
            model(sd, ud, mode, 8, 32, e.r1, e.o1);
            model(sd, ud, mode, 0, 16, e.r2, e.o2);
            q.push_back(e);
            sent++;
         end
         stall = out_valid0 && !out_ready;
         held_a = {res0, res1};
         held_b = {res2, ovf0, ovf1, ovf2, out_valid0};
      end
      check("rand_beats_received", got, NB);
      check("rand_queue_empty", q.size(), 0);

      in_valid = 1'b0;
      out_ready = 1'b1;
      nv = 0;
      for (int k = 0; k < ST + 4; k++) begin
         @(negedge clk);
         #1;
         if (out_valid0) nv++;
      end
      check("rand_no_duplicates", nv, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul_sfx_ufx_pipe.md
MUL_SFX_UFX_PIPE -- requirements
Module: mul_sfx_ufx_pipe

Interface
REQ-001 SHALL have parameter SW, default 32, signed operand width in bits.
REQ-002 SHALL have parameter UW, default 8, unsigned operand width in bits.
REQ-003 SHALL have parameter OW, default 32, result width in bits.
REQ-004 SHALL have parameter FRAC, default 0, number of product fraction bits dropped; range 0..SW+UW-1.
REQ-005 SHALL have parameter STAGES, default 3, pipeline depth; range 2..6.
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all state is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, 1 bit, operand beat valid.
REQ-009 SHALL have port in_ready, output, 1 bit, block accepts a beat.
REQ-010 SHALL have port sd, input, SW bits, signed two's-complement operand.
REQ-011 SHALL have port ud, input, UW bits, unsigned operand.
REQ-012 SHALL have port mode, input, 2 bits: bit0 selects round-half-up (1) or truncate toward minus infinity (0); bit1 selects saturate (1) or wrap (0).
REQ-013 SHALL have port out_valid, output, 1 bit, result valid.
REQ-014 SHALL have port out_ready, input, 1 bit, downstream accepts the result.
REQ-015 SHALL have port result, output, OW bits, signed result.
REQ-016 SHALL have port ovf, output, 1 bit, result was out of OW range (saturated or wrapped).

Function
REQ-017 SHALL treat ud as zero-extended to UW+1 bits, so the full product is an exact signed value of SW+UW+1 bits.
REQ-018 SHALL shift right arithmetically by FRAC bits; with mode[0]=1 it SHALL add 2^(FRAC-1) before the shift (a no-op when FRAC=0).
REQ-019 With mode[1]=1, out-of-range values SHALL clamp to +2^(OW-1)-1 or -2^(OW-1); with mode[1]=0 the block SHALL output the low OW bits.
REQ-020 SHALL assert ovf with the beat whenever the shifted value does not fit in OW signed bits, regardless of mode[1].
REQ-021 SHALL sample mode together with its operands; mode SHALL travel with the beat, so modes may change on every beat.
REQ-022 A beat SHALL transfer on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-023 The pipeline SHALL advance when adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, with no dependence on in_valid).
REQ-024 Without stalls, the result SHALL appear with out_valid exactly STAGES cycles after input acceptance.
REQ-025 Throughput SHALL be one beat per cycle; empty stages (bubbles) SHALL be carried by a per-stage valid bit and SHALL never produce out_valid.
REQ-026 While out_valid=1 and out_ready=0, result, ovf and out_valid SHALL hold stable, and no beat SHALL be lost or duplicated.
REQ-027 The beat order SHALL be preserved.
REQ-028 If accept and output happen in the same cycle with the pipeline full, both transfers SHALL occur.

Reset
REQ-029 While rst_n=0: all stage valid bits and out_valid SHALL be 0; result and ovf SHALL be 0; in_ready SHALL be 1 once the block is out of reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight beats, with no output after release.
REQ-031 Data registers need not be reset; only valid bits and the output registers SHALL be.

Structure
REQ-032 Package mul_sfx_ufx_pkg SHALL hold the mode bit position constants (MODE_RND=0, MODE_SAT=1) and a product-width function SW+UW+1.
REQ-033 Sub-module sfx_round_sat SHALL implement the combinational round, shift, saturate/wrap and ovf logic, placed in the final stage.
REQ-034 The multiply SHALL occupy stages 1..STAGES-1 (product register retimed across them); round/sat SHALL occupy the last stage.

Verification
REQ-035 Defaults, sd=-200, ud=200, mode=00 -> result=-40000, ovf=0, 3 cycles after accept.
REQ-036 FRAC=8, sd=-200, ud=200: mode=00 -> -157; mode=01 -> -156; ovf=0 in both.
REQ-037 OW=16, sd=32767, ud=255: mode=10 -> 32767, ovf=1; mode=00 -> 32513, ovf=1; sd=-32768, ud=255, mode=10 -> -32768, ovf=1.
REQ-038 Random out_ready/in_valid, 1000 beats -> outputs match a reference model in order, values stable during stalls, no loss or duplication.
REQ-039 Three beats in flight, rst_n pulsed low for 1 cycle -> out_valid=0 with no outputs afterwards; the next beat's result appears STAGES cycles after accept.
REQ-040 Alternating mode per beat (00,01,10,11) at full rate -> each result uses its own mode.
